// File: rtl/remote_requester_pkg.sv
// remote_requester_pkg
//   Shared types and helpers for the remote_requester traffic source/checker.
//   - state_e     : top-level run state
//   - LFSR_SEED / LFSR_TAPS : response-throttle LFSR constants (used only when
//                   REMOTE_REQUESTER_THROTTLE_EN is defined)
//   - pack_req()  : builds a request word {seq, tag}
package remote_requester_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // 8-bit Fibonacci LFSR, taps 8,6,5,4 -> bit positions 7,5,4,3.
  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  // Request word is {seq, tag}; callers truncate the result to width_p.
  function automatic logic [63:0] pack_req(input logic [63:0] seq,
                                           input logic [63:0] tag,
                                           input int unsigned lg_els);
    return (seq << lg_els) | tag;
  endfunction

endpackage

// File: rtl/remote_requester_tag_alloc.sv
// remote_requester_tag_alloc
//   Combinational lowest-free-tag finder.
//   Ports:
//     mask_i     [els_p-1:0]    outstanding-tag bitmask (1 = in use)
//     tag_o      [lg_els_p-1:0] index of the lowest clear bit of mask_i
//     any_free_o                at least one bit of mask_i is clear
module remote_requester_tag_alloc
  import remote_requester_pkg::*;
#(
  parameter int els_p    = 8,
  parameter int lg_els_p = $clog2(els_p)
) (
  input  logic [els_p-1:0]    mask_i,
  output logic [lg_els_p-1:0] tag_o,
  output logic                any_free_o
);

  logic [els_p-1:0]                  free_vec;
  logic [els_p-1:0]                  lowest_vec;
  logic [lg_els_p-1:0][els_p-1:0]    bit_hits;

  assign free_vec   = ~mask_i;
  // x & -x isolates the lowest set bit of the free vector.
  assign lowest_vec = free_vec & (mask_i + els_p'(1));
  assign any_free_o = |free_vec;

  // One-hot to binary: tag bit b is the OR of every one-hot position whose
  // index has bit b set.
  genvar gi, gb;
  generate
    for (gi = 0; gi < els_p; gi++) begin : g_pos
      localparam logic [lg_els_p-1:0] idx_lp = lg_els_p'(gi);
      for (gb = 0; gb < lg_els_p; gb++) begin : g_bit
        assign bit_hits[gb][gi] = lowest_vec[gi] & idx_lp[gb];
      end
    end
    for (gb = 0; gb < lg_els_p; gb++) begin : g_enc
      assign tag_o[gb] = |bit_hits[gb];
    end
  endgenerate

endmodule

// File: rtl/remote_requester.sv
// remote_requester
//   Initiator-side test node: issues tagged requests {seq, tag} to a remote
//   responder, consumes echoed (possibly out-of-order) responses and checks
//   each against the outstanding mask and the per-tag expected sequence.
//   Optional macro REMOTE_REQUESTER_THROTTLE_EN gates response acceptance with
//   an LFSR to create backpressure on the return path.
//   Ports:
//     clk_i, reset_n_i   clock, asynchronous active-low reset
//     en_i               start, sampled in IDLE
//     v_o, data_o        request valid / {seq, tag}
//     yumi_i             request taken by remote (only while v_o)
//     v_i, data_i        response valid / echoed request word
//     yumi_o             response consumed this cycle
//     done_o             run complete (terminal until reset)
//     error_o            sticky bad-response flag
//     issued_o           requests taken by remote
//     returned_o         responses consumed
module remote_requester
  import remote_requester_pkg::*;
#(
  parameter int width_p    = 16,
  parameter int els_p      = 8,
  parameter int num_reqs_p = 64
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            en_i,
  output logic                            v_o,
  output logic [width_p-1:0]              data_o,
  input  logic                            yumi_i,
  input  logic                            v_i,
  input  logic [width_p-1:0]              data_i,
  output logic                            yumi_o,
  output logic                            done_o,
  output logic                            error_o,
  output logic [$clog2(num_reqs_p+1)-1:0] issued_o,
  output logic [$clog2(num_reqs_p+1)-1:0] returned_o
);

  localparam int lg_els_lp = $clog2(els_p);
  localparam int seq_w_lp  = width_p - lg_els_lp;
  localparam int cnt_w_lp  = $clog2(num_reqs_p+1);

  state_e                state_reg, state_next;
  logic                  req_v_reg;
  logic [width_p-1:0]    req_data_reg;
  logic [els_p-1:0]      mask_reg, mask_next;
  logic [cnt_w_lp-1:0]   loaded_reg, issued_reg, returned_reg;
  logic                  error_reg;
  logic [seq_w_lp-1:0]   seq_mem [els_p];

  logic [lg_els_lp-1:0]  alloc_tag;
  logic                  any_free;
  logic                  active;
  logic                  take_req;
  logic                  load;
  logic                  accept;
  logic                  bad_resp;
  logic                  yumi_gate;
  logic [lg_els_lp-1:0]  resp_tag;
  logic [seq_w_lp-1:0]   resp_seq;
  logic [seq_w_lp-1:0]   load_seq;

  assign resp_tag = data_i[lg_els_lp-1:0];
  assign resp_seq = data_i[width_p-1:lg_els_lp];
  // Sequence numbers wrap modulo 2^seq_w; the check compares truncated values.
  assign load_seq = seq_w_lp'(loaded_reg);

  // Allocation looks at the registered mask, so a tag freed this cycle only
  // becomes available next cycle.
  remote_requester_tag_alloc #(
    .els_p    (els_p),
    .lg_els_p (lg_els_lp)
  ) u_tag_alloc (
    .mask_i     (mask_reg),
    .tag_o      (alloc_tag),
    .any_free_o (any_free)
  );

`ifdef REMOTE_REQUESTER_THROTTLE_EN
  logic [7:0] lfsr_reg;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= {lfsr_reg[6:0], ^(lfsr_reg & LFSR_TAPS)};
    end
  end

  assign yumi_gate = lfsr_reg[0];
`else
  assign yumi_gate = 1'b1;
`endif

  always_comb begin
    state_next = state_reg;
    mask_next  = mask_reg;
    active     = (state_reg == ISSUE) || (state_reg == DRAIN);
    take_req   = req_v_reg & yumi_i;
    accept     = active & v_i & yumi_gate;
    bad_resp   = accept & (!mask_reg[resp_tag] || (resp_seq != seq_mem[resp_tag]));
    // Refill the request slot when it is empty or being taken this cycle.
    load       = (state_reg == ISSUE) && (!req_v_reg || take_req) && any_free &&
                 (loaded_reg < cnt_w_lp'(num_reqs_p));

    // Clear first, then set: if a bogus response names the tag being
    // allocated this cycle, the new request stays tracked.
    if (accept) mask_next[resp_tag]  = 1'b0;
    if (load)   mask_next[alloc_tag] = 1'b1;

    case (state_reg)
      IDLE:  if (en_i) state_next = ISSUE;
      ISSUE: if (take_req && (issued_reg == cnt_w_lp'(num_reqs_p - 1))) state_next = DRAIN;
      DRAIN: if ((mask_reg == '0) && !req_v_reg) state_next = DONE;
      DONE:  state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg    <= IDLE;
      req_v_reg    <= 1'b0;
      req_data_reg <= '0;
      mask_reg     <= '0;
      loaded_reg   <= '0;
      issued_reg   <= '0;
      returned_reg <= '0;
      error_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      mask_reg  <= mask_next;
      if (load) begin
        req_v_reg    <= 1'b1;
        req_data_reg <= width_p'(pack_req(64'(load_seq), 64'(alloc_tag),
                                          int'(lg_els_lp)));
        loaded_reg   <= loaded_reg + cnt_w_lp'(1);
      end else if (take_req) begin
        req_v_reg <= 1'b0;
      end
      if (take_req) issued_reg   <= issued_reg + cnt_w_lp'(1);
      if (accept)   returned_reg <= returned_reg + cnt_w_lp'(1);
      if (bad_resp) error_reg    <= 1'b1;
    end
  end

  // Expected-sequence storage; contents are only meaningful for set mask bits.
  always_ff @(posedge clk_i) begin
    if (load) seq_mem[alloc_tag] <= load_seq;
  end

  assign v_o        = req_v_reg;
  assign data_o     = req_data_reg;
  assign yumi_o     = accept;
  assign done_o     = (state_reg == DONE);
  assign error_o    = error_reg;
  assign issued_o   = issued_reg;
  assign returned_o = returned_reg;

endmodule

// File: tb/tb_remote_requester.sv
module tb_remote_requester;

  localparam int W    = 16;
  localparam int ELS  = 8;
  localparam int NREQ = 64;
  localparam int CW   = $clog2(NREQ+1);

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          en_i;
  logic          v_o;
  logic [W-1:0]  data_o;
  logic          yumi_i;
  logic          v_i;
  logic [W-1:0]  data_i;
  logic          yumi_o;
  logic          done_o;
  logic          error_o;
  logic [CW-1:0] issued_o;
  logic [CW-1:0] returned_o;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] resp_q[$];
  logic [W-1:0] issued_log[$];

  remote_requester #(
    .width_p    (W),
    .els_p      (ELS),
    .num_reqs_p (NREQ)
  ) dut (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .en_i       (en_i),
    .v_o        (v_o),
    .data_o     (data_o),
    .yumi_i     (yumi_i),
    .v_i        (v_i),
    .data_i     (data_i),
    .yumi_o     (yumi_o),
    .done_o     (done_o),
    .error_o    (error_o),
    .issued_o   (issued_o),
    .returned_o (returned_o)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct {
    logic          en;
    logic          yumi;
    logic          v;
    logic [W-1:0]  din;
    logic          exp_v;
    logic [W-1:0]  exp_data;
    logic          exp_yumi;
    logic [CW-1:0] exp_iss;
    logic [CW-1:0] exp_ret;
    logic          exp_err;
  } vec_t;

  vec_t vecs [10];
  logic [W-1:0] fm_data [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    en_i      = 1'b0;
    yumi_i    = 1'b0;
    v_i       = 1'b0;
    data_i    = '0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
  endtask

  task automatic start_run();
    next_cycle();
    en_i = 1'b1;
    next_cycle();
    en_i = 1'b0;
  endtask

  // Remote model: takes every request, echoes it in order one cycle later.
  task automatic run_to_done(input int budget, output bit ok);
    ok = 1'b0;
    resp_q.delete();
    issued_log.delete();
    for (int c = 0; c < budget; c++) begin
      @(posedge clk_i);
      #1;
      yumi_i = v_o;
      v_i    = (resp_q.size() > 0);
      data_i = v_i ? resp_q[0] : '0;
      @(negedge clk_i);
      if (v_o && yumi_i) begin
        resp_q.push_back(data_o);
        issued_log.push_back(data_o);
        $display("req  issued=%0d data=0x%04h", issued_o, data_o);
      end
      if (v_i && yumi_o) begin
        $display("rsp  returned=%0d data=0x%04h", returned_o, resp_q[0]);
        void'(resp_q.pop_front());
      end
      if (done_o) begin
        ok = 1'b1;
        break;
      end
    end
    yumi_i = 1'b0;
    v_i    = 1'b0;
  endtask

  initial begin
    bit ok;

    //            en    yumi  v     din       exp_v exp_data  yumi_o iss    ret    err
    vecs[0] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 7'd0, 7'd0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 7'd0, 7'd0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 7'd0, 7'd0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 7'd0, 7'd0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0009, 1'b0, 7'd1, 7'd0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0009, 1'b1, 7'd1, 7'd0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0009, 1'b0, 7'd1, 7'd1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 16'h0009, 1'b1, 16'h0010, 1'b1, 7'd2, 7'd1, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 16'h0010, 1'b1, 16'h0010, 1'b1, 7'd2, 7'd2, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0019, 1'b0, 7'd3, 7'd3, 1'b0};

    // Requests taken while filling every tag: {seq, tag} for seq 3..10.
    fm_data[0] = 16'h0019; fm_data[1] = 16'h0020; fm_data[2] = 16'h002A;
    fm_data[3] = 16'h0033; fm_data[4] = 16'h003C; fm_data[5] = 16'h0045;
    fm_data[6] = 16'h004E; fm_data[7] = 16'h0057;

    // ---------------- reset state ----------------
    do_reset();
    @(negedge clk_i);
    check("rst_v_o",      32'(v_o),        32'd0);
    check("rst_done",     32'(done_o),     32'd0);
    check("rst_error",    32'(error_o),    32'd0);
    check("rst_issued",   32'(issued_o),   32'd0);
    check("rst_returned", 32'(returned_o), 32'd0);

`ifndef REMOTE_REQUESTER_THROTTLE_EN
    // ---------------- table-driven opening sequence ----------------
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      en_i   = vecs[i].en;
      yumi_i = vecs[i].yumi;
      v_i    = vecs[i].v;
      data_i = vecs[i].din;
      @(negedge clk_i);
      $display("vec %0d en=%0b yumi=%0b v_i=%0b din=0x%04h -> v_o=%0b data_o=0x%04h yumi_o=%0b iss=%0d ret=%0d err=%0b",
               i, en_i, yumi_i, v_i, data_i, v_o, data_o, yumi_o, issued_o, returned_o, error_o);
      check($sformatf("vec%0d_v_o", i),      32'(v_o),        32'(vecs[i].exp_v));
      if (vecs[i].exp_v)
        check($sformatf("vec%0d_data", i),   32'(data_o),     32'(vecs[i].exp_data));
      check($sformatf("vec%0d_yumi_o", i),   32'(yumi_o),     32'(vecs[i].exp_yumi));
      check($sformatf("vec%0d_issued", i),   32'(issued_o),   32'(vecs[i].exp_iss));
      check($sformatf("vec%0d_returned", i), 32'(returned_o), 32'(vecs[i].exp_ret));
      check($sformatf("vec%0d_error", i),    32'(error_o),    32'(vecs[i].exp_err));
      check($sformatf("vec%0d_done", i),     32'(done_o),     32'd0);
    end
    en_i = 1'b0;
    v_i  = 1'b0;

    // ---------------- fill every tag with no responses ----------------
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      yumi_i = 1'b1;
      @(negedge clk_i);
      $display("fill %0d data_o=0x%04h", i, data_o);
      check($sformatf("fill%0d_v_o", i),  32'(v_o),    32'd1);
      check($sformatf("fill%0d_data", i), 32'(data_o), 32'(fm_data[i]));
    end
    next_cycle();
    yumi_i = 1'b0;
    @(negedge clk_i);
    check("full_v_o",    32'(v_o),      32'd0);
    check("full_issued", 32'(issued_o), 32'd11);

    // Return tag 3 (seq 6); its tag comes back with seq 11 two cycles later.
    next_cycle();
    v_i    = 1'b1;
    data_i = 16'h0033;
    @(negedge clk_i);
    $display("rsp  tag3 data=0x%04h yumi_o=%0b", data_i, yumi_o);
    check("full_rsp_yumi_o", 32'(yumi_o), 32'd1);
    check("full_rsp_v_o",    32'(v_o),    32'd0);
    next_cycle();
    v_i = 1'b0;
    @(negedge clk_i);
    check("free_no_same_cycle_v_o", 32'(v_o), 32'd0);

    // ---------------- hold request under yumi_i low ----------------
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      yumi_i = 1'b0;
      @(negedge clk_i);
      $display("hold %0d v_o=%0b data_o=0x%04h", i, v_o, data_o);
      check($sformatf("hold%0d_v_o", i),    32'(v_o),      32'd1);
      check($sformatf("hold%0d_data", i),   32'(data_o),   32'h005B);
      check($sformatf("hold%0d_issued", i), 32'(issued_o), 32'd11);
    end
    next_cycle();
    yumi_i = 1'b1;
    next_cycle();
    yumi_i = 1'b0;
    @(negedge clk_i);
    check("hold_release_issued", 32'(issued_o), 32'd12);
    check("hold_release_v_o",    32'(v_o),      32'd0);
    check("hold_error",          32'(error_o),  32'd0);

    // ---------------- asynchronous reset mid-run ----------------
    @(posedge clk_i);
    #2;
    reset_n_i = 1'b0;
    #1;
    $display("async reset asserted mid-ISSUE");
    check("areset_v_o",      32'(v_o),        32'd0);
    check("areset_issued",   32'(issued_o),   32'd0);
    check("areset_returned", 32'(returned_o), 32'd0);
    check("areset_error",    32'(error_o),    32'd0);
    check("areset_done",     32'(done_o),     32'd0);
`endif

    // ---------------- full in-order run ----------------
    do_reset();
    start_run();
    run_to_done(2000, ok);
    @(negedge clk_i);
    check("run_done",     32'(ok),                32'd1);
    check("run_done_o",   32'(done_o),            32'd1);
    check("run_issued",   32'(issued_o),          32'd64);
    check("run_returned", 32'(returned_o),        32'd64);
    check("run_error",    32'(error_o),           32'd0);
    check("run_count",    32'(issued_log.size()), 32'd64);
    if (issued_log.size() >= 2) begin
      check("run_first",  32'(issued_log[0]), 32'h0000);
      check("run_second", 32'(issued_log[1]), 32'h0009);
    end
    // DONE is terminal: no requests or acceptances.
    next_cycle();
    v_i    = 1'b1;
    data_i = 16'h0000;
    @(negedge clk_i);
    check("done_v_o",    32'(v_o),    32'd0);
    check("done_yumi_o", 32'(yumi_o), 32'd0);
    next_cycle();
    v_i = 1'b0;
    @(negedge clk_i);
    check("done_error",  32'(error_o), 32'd0);

`ifndef REMOTE_REQUESTER_THROTTLE_EN
    // ---------------- response for a tag not outstanding ----------------
    do_reset();
    start_run();
    next_cycle();
    v_i    = 1'b1;
    data_i = 16'h0002;
    @(negedge clk_i);
    $display("rsp  bogus tag2 data=0x%04h", data_i);
    check("badtag_yumi_o", 32'(yumi_o),  32'd1);
    check("badtag_pre",    32'(error_o), 32'd0);
    next_cycle();
    v_i = 1'b0;
    @(negedge clk_i);
    check("badtag_error", 32'(error_o), 32'd1);
    run_to_done(2000, ok);
    @(negedge clk_i);
    check("badtag_run_done", 32'(ok),         32'd1);
    check("badtag_sticky",   32'(error_o),    32'd1);
    check("badtag_returned", 32'(returned_o), 32'd65);

    // ---------------- sequence mismatch on an outstanding tag ----------------
    do_reset();
    start_run();
    next_cycle();
    v_i    = 1'b1;
    data_i = 16'h0028;
    @(negedge clk_i);
    $display("rsp  bad seq tag0 data=0x%04h", data_i);
    check("badseq_pre", 32'(error_o), 32'd0);
    next_cycle();
    v_i = 1'b0;
    @(negedge clk_i);
    check("badseq_error", 32'(error_o), 32'd1);
    check("badseq_v_o",   32'(v_o),     32'd1);
    check("badseq_data",  32'(data_o),  32'h0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
